// File: rtl/spi_pkg.sv
// Shared types and helpers for the single-word SPI master.
// Holds the controller state encoding and the SCLK half-period divider.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } spi_state_e;

    // Half SCLK period in clk cycles, never below one cycle.
    function automatic int spi_half(input int sys_hz, input int sclk_hz);
        int h;
        h = sys_hz / (2 * sclk_hz);
        if (h < 1) begin
            h = 1;
        end
        return h;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host handshake and SPI pin bundle for spi_master_ctrl.
// master is the controller's view; slave is the host/pad view.
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH = 16
);

    logic                  start;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  done;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  ss;

    modport master (
        input  start,
        input  wr_data,
        input  miso,
        output rd_data,
        output busy,
        output done,
        output sclk,
        output mosi,
        output ss
    );

    modport slave (
        output start,
        output wr_data,
        output miso,
        input  rd_data,
        input  busy,
        input  done,
        input  sclk,
        input  mosi,
        input  ss
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, registered sclk, edge strobes.
// Strobes are high in the cycle before sclk actually toggles.
module spi_sclk_gen #(
    parameter int HALF = 125,
    parameter bit CPOL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    output logic sclk,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    assign tick       = en && (cnt == CNT_MAX);
    assign lead_edge  = tick && toggle_en && (sclk == CPOL);
    assign trail_edge = tick && toggle_en && (sclk != CPOL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= CPOL;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= CPOL;
        end else if (tick) begin
            cnt <= '0;
            if (toggle_en) begin
                sclk <= ~sclk;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-word SPI master: FSM, tx/rx shift registers, edge counter.
// SCLK timing comes from spi_sclk_gen; all pins are registered.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter bit CLK_POLARITY = 1'b0,
    parameter bit CLK_PHASE    = 1'b0,
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int SCLK_FREQ    = 400_000,
    parameter int DATA_WIDTH   = 16
) (
    input logic              clk,
    input logic              rst,
    spi_master_ctrl_if.master bus
);

    localparam int HALF = spi_half(SYS_CLK_FREQ, SCLK_FREQ);
    localparam int ECW  = $clog2(2 * DATA_WIDTH);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_WIDTH - 1);

    spi_state_e            state;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [ECW-1:0]        edge_cnt;

    logic gen_en;
    logic toggle_en;
    logic tick;
    logic lead_edge;
    logic trail_edge;
    logic last_edge;
    logic sample_edge;
    logic shift_edge;

    assign gen_en    = (state != IDLE);
    assign toggle_en = (state == LEAD) || (state == SHIFT);
    assign last_edge = (edge_cnt == LAST_EDGE);
    assign tx_next   = tx_sr << 1;

    // CPHA=0 already drove the MSB at select time, so the final
    // trailing edge has no further bit to present.
    assign sample_edge = CLK_PHASE ? trail_edge : lead_edge;
    assign shift_edge  = CLK_PHASE ? lead_edge
                                   : (trail_edge && !last_edge);

    spi_sclk_gen #(
        .HALF (HALF),
        .CPOL (CLK_POLARITY)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (gen_en),
        .toggle_en  (toggle_en),
        .sclk       (bus.sclk),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_sr       <= '0;
            rx_sr       <= '0;
            edge_cnt    <= '0;
            bus.rd_data <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.ss      <= 1'b1;
            bus.mosi    <= 1'b0;
        end else begin
            bus.done <= 1'b0;

            if (sample_edge) begin
                rx_sr <= (rx_sr << 1) | DATA_WIDTH'(bus.miso);
            end

            if (shift_edge) begin
                tx_sr    <= tx_next;
                bus.mosi <= CLK_PHASE ? tx_sr[DATA_WIDTH-1]
                                      : tx_next[DATA_WIDTH-1];
            end

            if (tick && toggle_en) begin
                edge_cnt <= edge_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    // done still high means this is the completion
                    // cycle; a restart is only taken one cycle later.
                    if (bus.start && !bus.done) begin
                        tx_sr    <= bus.wr_data;
                        rx_sr    <= '0;
                        edge_cnt <= '0;
                        bus.ss   <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= LEAD;
                        if (!CLK_PHASE) begin
                            bus.mosi <= bus.wr_data[DATA_WIDTH-1];
                        end
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick && last_edge) begin
                        state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        bus.ss      <= 1'b1;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.rd_data <= rx_sr;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: mode-0 and mode-3 instances,
// loopback or a behavioural mode-0 slave on MISO.
module tb_spi_master_ctrl;

    localparam int H   = 125;
    localparam int LAT = 1 + 33 * H;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DATA_WIDTH(16)) if0 ();
    spi_master_ctrl_if #(.DATA_WIDTH(16)) if3 ();

    spi_master_ctrl u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    spi_master_ctrl #(
        .CLK_POLARITY (1'b1),
        .CLK_PHASE    (1'b1)
    ) u3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    // Behavioural mode-0 slave on the mode-0 instance.
    logic        use_slave = 1'b0;
    logic [15:0] s_tx      = 16'h0;
    logic [15:0] s_rx      = 16'h0;
    int          rise_cnt  = 0;
    logic        p_sclk    = 1'b0;
    logic        p_ss      = 1'b1;

    always @(if0.sclk, if0.ss) begin
        if (p_ss === 1'b1 && if0.ss === 1'b0) begin
            s_tx     = 16'h3C3C;
            s_rx     = 16'h0;
            rise_cnt = 0;
        end else if (if0.ss === 1'b0 && !p_sclk && if0.sclk) begin
            s_rx     = {s_rx[14:0], if0.mosi};
            rise_cnt = rise_cnt + 1;
        end else if (if0.ss === 1'b0 && p_sclk && !if0.sclk) begin
            s_tx = s_tx << 1;
        end
        p_sclk = if0.sclk;
        p_ss   = if0.ss;
    end

    assign if0.miso = use_slave ? s_tx[15] : if0.mosi;
    assign if3.miso = if3.mosi;

    // Mode 3: mosi may only move together with a falling sclk.
    int   mosi_bad = 0;
    logic pm3      = 1'b0;
    logic ps3      = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (if3.mosi !== pm3 && !(ps3 && !if3.sclk)) begin
                mosi_bad = mosi_bad + 1;
            end
        end
        pm3 = if3.mosi;
        ps3 = if3.sclk;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit d3, input logic st,
                         input logic [15:0] w);
        if (d3) begin
            if3.start   = st;
            if3.wr_data = w;
        end else begin
            if0.start   = st;
            if0.wr_data = w;
        end
    endtask

    task automatic do_xfer(
        input  bit          d3,
        input  logic [15:0] w,
        input  int          poke_at,
        output logic [15:0] rd,
        output int          lat,
        output int          ss_low,
        output int          n_done,
        output int          n_edge,
        output int          e1,
        output int          e3,
        output logic        mosi1,
        output logic        busy1
    );
        logic ps, cs, dn;
        @(negedge clk);
        drive(d3, 1'b1, w);
        @(negedge clk);
        drive(d3, 1'b0, w);
        lat    = 1;
        n_done = 0;
        n_edge = 0;
        e1     = 0;
        e3     = 0;
        mosi1  = d3 ? if3.mosi : if0.mosi;
        busy1  = d3 ? if3.busy : if0.busy;
        ps     = d3 ? if3.sclk : if0.sclk;
        ss_low = ((d3 ? if3.ss : if0.ss) == 1'b0) ? 1 : 0;
        dn     = 1'b0;
        while (!dn && lat < 6000) begin
            @(negedge clk);
            lat++;
            if (lat == poke_at) drive(d3, 1'b1, 16'hFFFF);
            if (lat == poke_at + 1) drive(d3, 1'b0, 16'hFFFF);
            cs = d3 ? if3.sclk : if0.sclk;
            if (cs != ps) begin
                n_edge++;
                if (n_edge == 1) e1 = lat;
                if (n_edge == 3) e3 = lat;
            end
            ps = cs;
            if ((d3 ? if3.ss : if0.ss) == 1'b0) ss_low++;
            dn = d3 ? if3.done : if0.done;
            if (dn) n_done++;
        end
        rd = d3 ? if3.rd_data : if0.rd_data;
        repeat (4) begin
            @(negedge clk);
            if (d3 ? if3.done : if0.done) n_done++;
        end
    endtask

    typedef struct {
        bit          d3;
        bit          slave;
        logic [15:0] wr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [15:0] rd;
        int          lat, ss_low, n_done, n_edge, e1, e3, t;
        logic        mosi1, busy1;
        bit          cpol;

        vt[0] = '{d3: 1'b0, slave: 1'b0, wr: 16'hA5A5, exp_rd: 16'hA5A5};
        vt[1] = '{d3: 1'b0, slave: 1'b1, wr: 16'hA5A5, exp_rd: 16'h3C3C};
        vt[2] = '{d3: 1'b1, slave: 1'b0, wr: 16'h8001, exp_rd: 16'h8001};
        vt[3] = '{d3: 1'b0, slave: 1'b0, wr: 16'h6C19, exp_rd: 16'h6C19};
        vt[4] = '{d3: 1'b1, slave: 1'b0, wr: 16'h5A3C, exp_rd: 16'h5A3C};

        drive(1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_sclk0", {31'd0, if0.sclk}, 32'd0);
        chk("rst_sclk3", {31'd0, if3.sclk}, 32'd1);
        chk("rst_ss", {30'd0, if0.ss, if3.ss}, 32'd3);
        chk("rst_mosi", {30'd0, if0.mosi, if3.mosi}, 32'd0);
        chk("rst_busy", {30'd0, if0.busy, if3.busy}, 32'd0);
        chk("rst_done", {30'd0, if0.done, if3.done}, 32'd0);
        chk("rst_rd", {if0.rd_data, if3.rd_data}, 32'd0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            use_slave = vt[i].slave;
            cpol      = vt[i].d3;
            do_xfer(vt[i].d3, vt[i].wr, 0, rd, lat, ss_low, n_done,
                    n_edge, e1, e3, mosi1, busy1);
            chk($sformatf("v%0d_rd", i), {16'd0, rd}, {16'd0, vt[i].exp_rd});
            chk($sformatf("v%0d_lat", i), lat, LAT);
            chk($sformatf("v%0d_ss_low", i), ss_low, 33 * H);
            chk($sformatf("v%0d_done_cnt", i), n_done, 1);
            chk($sformatf("v%0d_edges", i), n_edge, 32);
            chk($sformatf("v%0d_first_edge", i), e1, 1 + H);
            chk($sformatf("v%0d_period", i), e3 - e1, 2 * H);
            chk($sformatf("v%0d_busy1", i), {31'd0, busy1}, 32'd1);
            chk($sformatf("v%0d_sclk_idle", i),
                {31'd0, vt[i].d3 ? if3.sclk : if0.sclk}, {31'd0, cpol});
            if (!vt[i].d3) begin
                chk($sformatf("v%0d_mosi1", i), {31'd0, mosi1},
                    {31'd0, vt[i].wr[15]});
            end
            if (vt[i].slave) begin
                chk($sformatf("v%0d_slave_rx", i), {16'd0, s_rx}, 32'hA5A5);
                chk($sformatf("v%0d_slave_rises", i), rise_cnt, 16);
            end
        end
        use_slave = 1'b0;
        chk("mode3_mosi_on_fall", mosi_bad, 0);

        // start during a transfer is dropped
        do_xfer(1'b0, 16'h1357, 100, rd, lat, ss_low, n_done,
                n_edge, e1, e3, mosi1, busy1);
        chk("busy_start_rd", {16'd0, rd}, 32'h1357);
        chk("busy_start_done", n_done, 1);
        chk("busy_start_lat", lat, LAT);

        // start in the done cycle is dropped, next cycle is taken
        @(negedge clk);
        drive(1'b0, 1'b1, 16'hA5A5);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'hA5A5);
        t = 0;
        while (!if0.done && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk("seq_done_seen", {31'd0, if0.done}, 32'd1);
        drive(1'b0, 1'b1, 16'hFFFF);
        @(negedge clk);
        chk("start_on_done_ignored", {31'd0, if0.busy}, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'hFFFF);
        chk("restart_after_done", {31'd0, if0.busy}, 32'd1);
        t = 0;
        while (!if0.done && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk("restart_rd", {16'd0, if0.rd_data}, 32'hFFFF);

        // reset in the middle of a transfer
        @(negedge clk);
        drive(1'b0, 1'b1, 16'hBEEF);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'hBEEF);
        n_done = 0;
        for (int c = 1; c < 2000; c++) begin
            @(negedge clk);
            if (if0.done) n_done++;
        end
        chk("abort_no_done_before", n_done, 0);
        chk("abort_busy_before", {31'd0, if0.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ss", {31'd0, if0.ss}, 32'd1);
        chk("abort_sclk", {31'd0, if0.sclk}, 32'd0);
        chk("abort_busy", {31'd0, if0.busy}, 32'd0);
        chk("abort_done", {31'd0, if0.done}, 32'd0);
        chk("abort_rd", {16'd0, if0.rd_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_xfer(1'b0, 16'h1234, 0, rd, lat, ss_low, n_done,
                n_edge, e1, e3, mosi1, busy1);
        chk("post_abort_rd", {16'd0, rd}, 32'h1234);
        chk("post_abort_done", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
